uart_tx_mmio: RTL and testbench

Memory-mapped serial transmitter sitting downstream of the processor's address/data-out/write outputs, alongside the RAM, LED register and 7-segment scroller on the chip-select decode. Processor `st` instructions push bytes into a small FIFO; an internal state machine serialises them as 8N1 frames on `txd`. A status word is returned combinationally on `rd_data` so software can poll with `ld` before writing, because the processor has no stall input.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/fifo_sync.sv | 70 +++++++
 rtl/uart_tx_mmio.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the transmitter state encoding, the register offsets decoded on
// addr[0], and the bit positions of the fields inside the STATUS word.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_e;

  localparam logic DATA_OFS = 1'b0;
  localparam logic STAT_OFS = 1'b1;

  localparam int FULL    = 0;
  localparam int EMPTY   = 1;
  localparam int ACTIVE  = 2;
  localparam int OVF     = 3;
  localparam int CNT_LSB = 4;

endpackage

// File: rtl/fifo_sync.sv
// Small synchronous byte FIFO used as the transmit queue.
// Ports:
//   Clock     - single clock, all state changes on the rising edge
//   Resetn    - synchronous active-low reset, empties the queue
//   i_push    - write i_wrData at the tail (caller guarantees room)
//   i_pop     - drop the head entry (caller guarantees non-empty)
//   i_wrData  - byte to enqueue
//   o_rdData  - current head entry, valid whenever o_empty is low
//   o_full    - count equals DEPTH
//   o_empty   - count equals zero
//   o_count   - number of stored bytes, 0..DEPTH
module fifo_sync #(
  parameter int DEPTH = 4
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [7:0]                   i_wrData,
  output logic [7:0]                   o_rdData,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  // Storage is left unreset on purpose: the count decides which entries
  // are meaningful, so stale bytes after reset are never observed.
  always_ff @(posedge Clock) begin
    if (i_push) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  // Pointers are exactly AW bits wide and DEPTH is a power of two, so they
  // wrap around the storage on their own. The count moves only when a push
  // and a pop do not cancel each other out.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (i_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!i_push && i_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign o_rdData = r_mem[r_rdPtr];
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 serial transmitter.
// Processor stores to offset 0 queue a byte; a state machine sends each
// queued byte LSB first with one start and one stop bit. Offset 1 returns
// a status word combinationally so software can poll before storing.
// Ports:
//   Clock    - single clock, rising edge
//   Resetn   - synchronous active-low reset, aborts any frame in flight
//   addr     - processor address; [15:12] selects the block, [0] the register
//   data_in  - processor store data; [7:0] is the byte, [3] clears overflow
//   write    - one-cycle store strobe
//   sel      - combinational block select, used by the read mux
//   rd_data  - combinational register read data
//   txd      - registered serial line, idles high
//   busy     - registered: frame in progress or bytes still queued
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         DEPTH        = 4,
  parameter logic [3:0] BASE         = 4'h3
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        write,
  output logic        sel,
  output logic [15:0] rd_data,
  output logic        txd,
  output logic        busy
);

  localparam int          CW        = $clog2(DEPTH+1);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  txState_e      r_state;
  logic [15:0]   r_baudCnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_busy;
  logic          r_ovf;

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_countNext;
  logic [7:0]    w_fifoData;
  logic          w_pushReq;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_clrOvf;
  logic          w_baudEnd;
  logic          w_active;
  logic          w_nextActive;
  logic          w_unused;

  assign sel       = (addr[15:12] == BASE);
  assign w_pushReq = sel && write && (addr[0] == DATA_OFS);
  assign w_clrOvf  = sel && write && (addr[0] == STAT_OFS) && data_in[3];
  assign w_unused  = ^{addr[11:1], data_in[15:8]};

  assign w_baudEnd = (r_baudCnt == BAUD_LAST);
  assign w_active  = (r_state != IDLE);

  // A byte leaves the queue either straight from idle or at the very end of
  // a stop bit, which is what lets queued bytes go out with no idle gap.
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_baudEnd));

  // A full queue still accepts a byte when the head is leaving on the same
  // edge; otherwise the byte is lost and the overflow flag records it.
  assign w_push = w_pushReq && (!w_full || w_pop);
  assign w_drop = w_pushReq && w_full && !w_pop;

  // busy is registered from the post-edge view of the machine, so it rises
  // with the accepting edge and falls on the same edge the stop bit ends.
  assign w_countNext  = w_count + CW'(w_push) - CW'(w_pop);
  assign w_nextActive = (r_state == IDLE) ? w_pop
                                          : !((r_state == STOP) && w_baudEnd && !w_pop);

  fifo_sync #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wrData(data_in[7:0]),
    .o_rdData(w_fifoData),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Transmit state machine. txd is registered, so each transition loads
  // the level for the state being entered. In DATA the next bit is taken
  // from shift[1] at the same edge the register shifts right, which is the
  // bit that sits in shift[0] afterwards. The baud counter restarts on
  // every state change so each state lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state   <= IDLE;
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= w_nextActive || (w_countNext != '0);
      case (r_state)
        IDLE: begin
          r_txd     <= 1'b1;
          r_baudCnt <= '0;
          if (w_pop) begin
            r_shift <= w_fifoData;
            r_txd   <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_baudEnd) begin
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_txd     <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_baudCnt <= r_baudCnt + 16'd1;
          end
        end
        DATA: begin
          if (w_baudEnd) begin
            r_baudCnt <= '0;
            if (r_bitIdx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= STOP;
            end else begin
              r_shift  <= r_shift >> 1;
              r_bitIdx <= r_bitIdx + 3'd1;
              r_txd    <= r_shift[1];
            end
          end else begin
            r_baudCnt <= r_baudCnt + 16'd1;
          end
        end
        STOP: begin
          if (w_baudEnd) begin
            r_baudCnt <= '0;
            if (w_pop) begin
              r_shift <= w_fifoData;
              r_txd   <= 1'b0;
              r_state <= START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_baudCnt <= r_baudCnt + 16'd1;
          end
        end
        default: begin
          r_txd     <= 1'b1;
          r_baudCnt <= '0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Sticky overflow flag. A dropped byte wins over a clear arriving on the
  // same edge so that a loss is never silently hidden from software.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_clrOvf) begin
      r_ovf <= 1'b0;
    end
  end

  // Register read mux. DATA reads as zero; STATUS packs the queue flags,
  // the transmitter activity, the overflow flag and the zero-extended count.
  always_comb begin
    rd_data = '0;
    if (sel && (addr[0] == STAT_OFS)) begin
      rd_data[FULL]           = w_full;
      rd_data[EMPTY]          = w_empty;
      rd_data[ACTIVE]         = w_active;
      rd_data[OVF]            = r_ovf;
      rd_data[CNT_LSB +: 5]   = 5'(w_count);
    end
  end

  assign txd  = r_txd;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4, DEPTH=4, BASE=3).
// A behavioural model tracks a byte queue and a frame position counter and
// derives the expected line level, busy and status word every cycle.
module tb_uart_tx_mmio;

  localparam int         CPB   = 4;
  localparam int         DEPTH = 4;
  localparam logic [3:0] BASE  = 4'h3;

  logic        Clock;
  logic        Resetn;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        write;
  logic        sel;
  logic [15:0] rd_data;
  logic        txd;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int edgeN = 0;

  logic [7:0] fifoQ[$];
  logic [7:0] mCur;
  logic       mActive;
  int         mPos;
  logic       mOvf;
  logic       mValid = 1'b0;
  logic       mPushReq;
  logic       mClr;

  typedef struct {
    logic [15:0] vAddr;
    logic        expSel;
    logic [15:0] expRd;
  } decodeVec_t;

  decodeVec_t vecs[8];

  uart_tx_mmio #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH),
    .BASE        (BASE)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .addr   (addr),
    .data_in(data_in),
    .write  (write),
    .sel    (sel),
    .rd_data(rd_data),
    .txd    (txd),
    .busy   (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d, input logic w);
    addr    = a;
    data_in = d;
    write   = w;
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
    #1;
    edgeN++;
  endtask

  task automatic advanceTo(input int target);
    while (edgeN < target) tick();
  endtask

  function automatic logic modelTxd();
    int slot;
    if (!mActive) return 1'b1;
    slot = mPos / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return mCur[slot-1];
  endfunction

  function automatic logic [15:0] modelRd(input logic [15:0] a);
    logic [15:0] s;
    s = '0;
    if (a[15:12] == BASE && a[0]) begin
      s[0]   = (fifoQ.size() == DEPTH);
      s[1]   = (fifoQ.size() == 0);
      s[2]   = mActive;
      s[3]   = mOvf;
      s[8:4] = 5'(fifoQ.size());
    end
    return s;
  endfunction

  // Reference model: each frame is 10*CPB cycles long; a finishing frame
  // immediately takes the next queued byte, and the queue is consulted for
  // a pop before the new byte (if any) is appended.
  always @(posedge Clock) begin
    if (!Resetn) begin
      fifoQ.delete();
      mActive = 1'b0;
      mPos    = 0;
      mOvf    = 1'b0;
      mCur    = '0;
      mValid  = 1'b1;
    end else begin
      mPushReq = write && (addr[15:12] == BASE) && !addr[0];
      mClr     = write && (addr[15:12] == BASE) && addr[0] && data_in[3];
      if (mActive) begin
        mPos++;
        if (mPos == 10*CPB) begin
          mPos = 0;
          if (fifoQ.size() > 0) mCur = fifoQ.pop_front();
          else mActive = 1'b0;
        end
      end else if (fifoQ.size() > 0) begin
        mCur    = fifoQ.pop_front();
        mActive = 1'b1;
        mPos    = 0;
      end
      if (mPushReq && fifoQ.size() >= DEPTH) mOvf = 1'b1;
      else if (mClr) mOvf = 1'b0;
      if (mPushReq && fifoQ.size() < DEPTH) fifoQ.push_back(data_in[7:0]);
    end
  end

  // Every cycle, once the model has seen a reset, compare all outputs.
  always @(negedge Clock) begin
    if (mValid) begin
      checkOutput("txd_model",  16'(txd),  16'(modelTxd()));
      checkOutput("busy_model", 16'(busy), 16'(mActive || fifoQ.size() != 0));
      checkOutput("sel_model",  16'(sel),  16'(addr[15:12] == BASE));
      checkOutput("rd_model",   rd_data,   modelRd(addr));
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] a5Bits [10];
    a5Bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    vecs[0] = '{16'h3000, 1'b1, 16'h0000};
    vecs[1] = '{16'h3001, 1'b1, 16'h0002};
    vecs[2] = '{16'h3FFF, 1'b1, 16'h0002};
    vecs[3] = '{16'h3FFE, 1'b1, 16'h0000};
    vecs[4] = '{16'h2001, 1'b0, 16'h0000};
    vecs[5] = '{16'h4001, 1'b0, 16'h0000};
    vecs[6] = '{16'h0000, 1'b0, 16'h0000};
    vecs[7] = '{16'hF001, 1'b0, 16'h0000};

    $display("[TB] reset");
    Resetn = 1'b0;
    applyStimulus(16'h3001, 16'h0000, 1'b0);
    tick();
    tick();
    checkOutput("reset_txd",    16'(txd),  16'h1);
    checkOutput("reset_busy",   16'(busy), 16'h0);
    checkOutput("reset_status", rd_data,   16'h0002);
    Resetn = 1'b1;
    tick();

    $display("[TB] decode table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].vAddr, 16'h0000, 1'b0);
      checkOutput("decode_sel", 16'(sel), 16'(vecs[i].expSel));
      checkOutput("decode_rd",  rd_data,  vecs[i].expRd);
      tick();
    end

    $display("[TB] single byte 0xA5");
    applyStimulus(16'h3000, 16'h00A5, 1'b1);
    checkOutput("push_same_cycle_status_pre", 16'(busy), 16'h0);
    tick();
    applyStimulus(16'h3001, 16'h0000, 1'b0);
    tick();
    edgeN = 0;
    checkOutput("a5_start_fall", 16'(txd), 16'h0);
    for (int k = 0; k < 10; k++) begin
      advanceTo(4*k + 2);
      checkOutput("a5_bit", 16'(txd), 16'(a5Bits[k]));
    end
    advanceTo(39);
    checkOutput("a5_busy_last", 16'(busy), 16'h1);
    advanceTo(40);
    checkOutput("a5_busy_drop", 16'(busy), 16'h0);
    checkOutput("a5_idle_txd",  16'(txd),  16'h1);
    tick();

    $display("[TB] back-to-back 01 02 03");
    applyStimulus(16'h3000, 16'h0001, 1'b1);
    tick();
    edgeN = -1;
    applyStimulus(16'h3000, 16'h0002, 1'b1);
    tick();
    applyStimulus(16'h3000, 16'h0003, 1'b1);
    tick();
    applyStimulus(16'h3001, 16'h0000, 1'b0);
    advanceTo(39);
    checkOutput("b2b_stop1",  16'(txd), 16'h1);
    advanceTo(40);
    checkOutput("b2b_start2", 16'(txd), 16'h0);
    advanceTo(79);
    checkOutput("b2b_stop2",  16'(txd), 16'h1);
    advanceTo(80);
    checkOutput("b2b_start3", 16'(txd), 16'h0);
    advanceTo(119);
    checkOutput("b2b_busy_last", 16'(busy), 16'h1);
    advanceTo(120);
    checkOutput("b2b_busy_drop", 16'(busy), 16'h0);
    tick();

    $display("[TB] overflow and full-plus-pop");
    edgeN = -2;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(16'h3000, 16'(8'h10 + i), 1'b1);
      tick();
    end
    applyStimulus(16'h3001, 16'h0000, 1'b0);
    checkOutput("ovf_status", rd_data, 16'h004D);
    applyStimulus(16'h3001, 16'h0008, 1'b1);
    tick();
    applyStimulus(16'h3001, 16'h0000, 1'b0);
    checkOutput("ovf_cleared", rd_data, 16'h0045);
    advanceTo(39);
    applyStimulus(16'h3000, 16'h0077, 1'b1);
    tick();
    applyStimulus(16'h3001, 16'h0000, 1'b0);
    checkOutput("fullpop_status", rd_data,   16'h0045);
    checkOutput("fullpop_start",  16'(txd),  16'h0);

    $display("[TB] reset mid-frame");
    advanceTo(57);
    Resetn = 1'b0;
    tick();
    checkOutput("midrst_txd",    16'(txd),  16'h1);
    checkOutput("midrst_busy",   16'(busy), 16'h0);
    checkOutput("midrst_status", rd_data,   16'h0002);
    Resetn = 1'b1;
    for (int i = 0; i < 60; i++) tick();
    checkOutput("midrst_quiet_txd",    16'(txd), 16'h1);
    checkOutput("midrst_quiet_status", rd_data,  16'h0002);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      int r;
      int pushThr;
      logic [15:0] rnd;
      r       = $urandom_range(0, 999);
      rnd     = 16'($urandom);
      pushThr = ((i % 600) < 300) ? 300 : 20;
      if (r < pushThr)
        applyStimulus({BASE, rnd[11:1], 1'b0}, rnd, 1'b1);
      else if (r < 360)
        applyStimulus({4'h5, rnd[11:0]}, rnd, 1'b1);
      else if (r < 420)
        applyStimulus({BASE, rnd[11:1], 1'b1}, rnd, 1'b1);
      else if (r < 422) begin
        Resetn = 1'b0;
        applyStimulus(16'h3001, rnd, rnd[0]);
      end else if (r < 700)
        applyStimulus({BASE, rnd[11:1], 1'b1}, rnd, 1'b0);
      else
        applyStimulus(rnd, rnd, 1'b0);
      tick();
      Resetn = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
